// File: rtl/eb_pkg.sv
// Shared sizing helpers for the elastic buffer family.
package eb_pkg;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return ($clog2(depth) < 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/eb_ptr.sv
// Wrapping index pointer over 0..DEPTH-1. The wrap is an explicit compare, so DEPTH
// does not have to be a power of two.
module eb_ptr
   import eb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      inc,
   input  logic                      clr,
   output logic [ptr_w(DEPTH)-1:0]   ptr
);

   localparam int PW = ptr_w(DEPTH);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   end

endmodule

// File: rtl/ebn_buf.sv
// N-entry elastic buffer with datapath. Every output is decoded from registers only,
// so there is no combinational path from input to output in either direction.
module ebn_buf
   import eb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AFULL = DEPTH - 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          t_0_data,
   input  logic                      t_0_valid,
   output logic                      t_0_ready,
   output logic [WIDTH-1:0]          i_0_data,
   output logic                      i_0_valid,
   input  logic                      i_0_ready,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      afull
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wp;
   logic [PW-1:0]               rp;
   logic                        push;
   logic                        pop;

   // A flush discards any handshake that shows up in the same cycle.
   assign push = t_0_valid & t_0_ready & ~flush;
   assign pop  = i_0_valid & i_0_ready & ~flush;

   eb_ptr #(.DEPTH(DEPTH)) u_wp (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (push),
      .clr     (flush),
      .ptr     (wp)
   );

   eb_ptr #(.DEPTH(DEPTH)) u_rp (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (pop),
      .clr     (flush),
      .ptr     (rp)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         mem <= '0;
      else if (push)
         mem[wp] <= t_0_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (flush)
         count <= '0;
      else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A pop while full frees the slot for the next cycle only.
   assign t_0_ready = (count != CW'(DEPTH));
   assign i_0_valid = (count != '0);
   assign i_0_data  = mem[rp];
   assign afull     = (count >= CW'(AFULL));

endmodule
